// File: rtl/queue_split_one_by_one.sv
// queue_split_one_by_one: demux one eot-delimited stream onto two registered outputs, alternating whole transactions
module queue_split_one_by_one #(
    parameter int W_DIN = 16,
    parameter int W_CNT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [W_DIN-1:0] din_data,
    input  logic             din_valid,
    output logic             din_ready,
    output logic [W_DIN-1:0] dout0_data,
    output logic             dout0_valid,
    input  logic             dout0_ready,
    output logic [W_DIN-1:0] dout1_data,
    output logic             dout1_valid,
    input  logic             dout1_ready,
    output logic             sel,
    output logic [W_CNT-1:0] tx_cnt0,
    output logic [W_CNT-1:0] tx_cnt1
);
    localparam logic [0:0] SEL0 = 1'b0;
    localparam logic [0:0] SEL1 = 1'b1;
    logic can_load0, can_load1, acc;
    // only the selected stage gates the input; the other drains on its own
    always_comb begin
        can_load0 = !dout0_valid || dout0_ready;
        can_load1 = !dout1_valid || dout1_ready;
        din_ready = (sel == SEL1) ? can_load1 : can_load0;
        acc       = din_valid && din_ready;
    end
    // route FSM: flip to the other output after an accepted eot beat
    always_ff @(posedge clk) begin
        if (rst)
            sel <= SEL0;
        else if (acc && din_data[W_DIN-1])
            sel <= (sel == SEL0) ? SEL1 : SEL0;
    end
    // output stage 0: load on accept while selected, else clear on handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            dout0_valid <= 1'b0;
        end else if (acc && sel == SEL0) begin
            dout0_data  <= din_data;
            dout0_valid <= 1'b1;
        end else if (dout0_ready) begin
            dout0_valid <= 1'b0;
        end
    end
    // output stage 1: same as stage 0 for the other route
    always_ff @(posedge clk) begin
        if (rst) begin
            dout1_valid <= 1'b0;
        end else if (acc && sel == SEL1) begin
            dout1_data  <= din_data;
            dout1_valid <= 1'b1;
        end else if (dout1_ready) begin
            dout1_valid <= 1'b0;
        end
    end
    // completed-transaction counters: eot beats handed off downstream, wrapping
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_cnt0 <= '0;
            tx_cnt1 <= '0;
        end else begin
            if (dout0_valid && dout0_ready && dout0_data[W_DIN-1])
                tx_cnt0 <= tx_cnt0 + 1'b1;
            if (dout1_valid && dout1_ready && dout1_data[W_DIN-1])
                tx_cnt1 <= tx_cnt1 + 1'b1;
        end
    end
endmodule

// File: tb/tb_queue_split_one_by_one.sv
// tb_queue_split_one_by_one: directed scoreboard bench for the one-by-one splitter
module tb_queue_split_one_by_one;
    localparam int W = 16;
    logic          clk = 0;
    logic          rst;
    logic [W-1:0]  din_data;
    logic          din_valid;
    logic          din_ready;
    logic [W-1:0]  dout0_data, dout1_data;
    logic          dout0_valid, dout1_valid;
    logic          dout0_ready, dout1_ready;
    logic          sel;
    logic [15:0]   tx_cnt0, tx_cnt1;
    logic          s_din_ready, s_v0, s_v1, s_sel;
    logic [W-1:0]  s_d0, s_d1;
    logic [1:0]    s_cnt0, s_cnt1;
    int            total = 0;
    int            bad = 0;
    logic [W-1:0]  q0[$], q1[$];
    logic          msel, mv0, mv1;
    logic [15:0]   mc0, mc1;
    logic          a;

    queue_split_one_by_one #(.W_DIN(W), .W_CNT(16)) dut (
        .clk(clk), .rst(rst),
        .din_data(din_data), .din_valid(din_valid), .din_ready(din_ready),
        .dout0_data(dout0_data), .dout0_valid(dout0_valid), .dout0_ready(dout0_ready),
        .dout1_data(dout1_data), .dout1_valid(dout1_valid), .dout1_ready(dout1_ready),
        .sel(sel), .tx_cnt0(tx_cnt0), .tx_cnt1(tx_cnt1)
    );

    queue_split_one_by_one #(.W_DIN(W), .W_CNT(2)) dut_small (
        .clk(clk), .rst(rst),
        .din_data(din_data), .din_valid(din_valid), .din_ready(s_din_ready),
        .dout0_data(s_d0), .dout0_valid(s_v0), .dout0_ready(dout0_ready),
        .dout1_data(s_d1), .dout1_valid(s_v1), .dout1_ready(dout1_ready),
        .sel(s_sel), .tx_cnt0(s_cnt0), .tx_cnt1(s_cnt1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(output logic acc);
        logic e_rdy, h0, h1;
        @(negedge clk);
        e_rdy = msel ? (!mv1 || dout1_ready) : (!mv0 || dout0_ready);
        chk("din_ready", din_ready, e_rdy);
        chk("sel", sel, msel);
        chk("dout0_valid", dout0_valid, mv0);
        chk("dout1_valid", dout1_valid, mv1);
        chk("tx_cnt0", tx_cnt0, mc0);
        chk("tx_cnt1", tx_cnt1, mc1);
        chk("small_tx_cnt0", s_cnt0, mc0[1:0]);
        chk("small_tx_cnt1", s_cnt1, mc1[1:0]);
        if (mv0) begin
            if (q0.size() == 0) chk("q0_underflow", 1, 0);
            else chk("dout0_data", dout0_data, q0[0]);
        end
        if (mv1) begin
            if (q1.size() == 0) chk("q1_underflow", 1, 0);
            else chk("dout1_data", dout1_data, q1[0]);
        end
        h0 = mv0 && dout0_ready && q0.size() != 0;
        h1 = mv1 && dout1_ready && q1.size() != 0;
        acc = din_valid && e_rdy;
        if (h0) begin
            if (q0[0][W-1]) mc0++;
            void'(q0.pop_front());
        end
        if (h1) begin
            if (q1[0][W-1]) mc1++;
            void'(q1.pop_front());
        end
        if (acc) begin
            if (msel) q1.push_back(din_data);
            else q0.push_back(din_data);
        end
        mv0 = (acc && !msel) ? 1'b1 : (h0 ? 1'b0 : mv0);
        mv1 = (acc && msel) ? 1'b1 : (h1 ? 1'b0 : mv1);
        if (acc && din_data[W-1]) msel = !msel;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        din_valid = 0;
        rst = 1;
        @(posedge clk);
        #1;
        rst = 0;
        msel = 0; mv0 = 0; mv1 = 0; mc0 = 0; mc1 = 0;
        q0.delete(); q1.delete();
        chk("rst_sel", sel, 0);
        chk("rst_v0", dout0_valid, 0);
        chk("rst_v1", dout1_valid, 0);
        chk("rst_cnt0", tx_cnt0, 0);
        chk("rst_cnt1", tx_cnt1, 0);
    endtask

    task automatic beat(input logic [W-1:0] d);
        logic acc;
        din_valid = 1;
        din_data = d;
        acc = 0;
        for (int n = 0; n < 20 && !acc; n++) step(acc);
        if (!acc) chk("beat_timeout", 0, 1);
    endtask

    task automatic idle(input int n);
        logic acc;
        din_valid = 0;
        for (int i = 0; i < n; i++) step(acc);
    endtask

    initial begin
        din_data = '0;
        din_valid = 0;
        dout0_ready = 1;
        dout1_ready = 1;
        rst = 1;
        repeat (2) @(posedge clk);
        do_reset();

        // 1: A0,A1,A2(eot) to dout0, B0,B1(eot) to dout1, back to back
        beat(16'h00A0); beat(16'h00A1); beat(16'h80A2);
        beat(16'h00B0); beat(16'h80B1);
        idle(3);
        chk("t1_cnt0", tx_cnt0, 1);
        chk("t1_cnt1", tx_cnt1, 1);

        // 2: stalled dout0 blocks the next beat, then pass-through on release
        do_reset();
        dout0_ready = 0;
        beat(16'h00C0);
        din_data = 16'h00C1;
        step(a);
        chk("t2_blocked", a, 0);
        chk("t2_hold", dout0_data, 16'h00C0);
        dout0_ready = 1;
        step(a);
        chk("t2_pass_acc", a, 1);
        chk("t2_pass_data", dout0_data, 16'h00C1);
        chk("t2_pass_valid", dout0_valid, 1);
        beat(16'h80C2);
        idle(3);

        // 3: eot parked on stalled dout0; next transaction flows into dout1
        do_reset();
        dout0_ready = 0;
        beat(16'h80D0);
        beat(16'h00E0);
        beat(16'h80E1);
        idle(2);
        chk("t3_sel", sel, 0);
        chk("t3_hold", dout0_data, 16'h80D0);
        chk("t3_cnt1", tx_cnt1, 1);
        dout0_ready = 1;
        idle(2);
        chk("t3_cnt0", tx_cnt0, 1);

        // 4: single-beat transactions alternate per beat
        do_reset();
        for (int i = 0; i < 6; i++) beat(16'h8050 + 16'(i));
        idle(3);
        chk("t4_cnt0", tx_cnt0, 3);
        chk("t4_cnt1", tx_cnt1, 3);

        // 5: narrow counters wrap after the 4th eot on each output
        do_reset();
        for (int i = 0; i < 6; i++) beat(16'h8060 + 16'(i));
        idle(3);
        chk("t5_small0_3", s_cnt0, 3);
        chk("t5_small1_3", s_cnt1, 3);
        for (int i = 6; i < 8; i++) beat(16'h8060 + 16'(i));
        idle(3);
        chk("t5_small0_wrap", s_cnt0, 0);
        chk("t5_small1_wrap", s_cnt1, 0);
        chk("t5_wide0", tx_cnt0, 4);

        // 6: reset while dout1 holds a beat mid-transaction
        do_reset();
        dout1_ready = 0;
        beat(16'h80F0);
        beat(16'h00F1);
        idle(1);
        chk("t6_pre_sel", sel, 1);
        chk("t6_pre_v1", dout1_valid, 1);
        dout1_ready = 1;
        do_reset();
        beat(16'h0077);
        chk("t6_route_v0", dout0_valid, 1);
        chk("t6_route_d0", dout0_data, 16'h0077);
        chk("t6_route_v1", dout1_valid, 0);
        beat(16'h8078);
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
